// File: rtl/joypad_poller.sv
// NES pad poller: periodically shifts the 8 buttons out of the physical pad, then replays the
// captured word to the NES core through an emulated 4021 shift register clocked by the core.
module joypad_poller #(
    parameter int DIV         = 64,
    parameter int POLL_PERIOD = 357954
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons,
    output logic       valid,
    input  logic       nes_strobe,
    input  logic       nes_clock,
    output logic       nes_data
);

    localparam int PW = $clog2(POLL_PERIOD);
    localparam int CW = $clog2(2 * DIV);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_PERIOD - 1);
    localparam logic [CW-1:0] LATCH_LOAD  = CW'(2 * DIV - 1);
    localparam logic [CW-1:0] CLK_LOAD    = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_HI,
        CLK_LO,
        DONE
    } state_t;

    state_t        state;
    logic          pd_meta;
    logic          pd_s;
    logic [PW-1:0] period_cnt;
    logic [CW-1:0] cyc_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    captured;
    logic          poll_start;
    logic          nclk_q;
    logic [7:0]    sreg;

    // Pad data is asynchronous and only ever sampled well after a pad edge, so no reset is needed.
    always_ff @(posedge clock) begin
        pd_meta <= pad_data;
        pd_s    <= pd_meta;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (period_cnt == PERIOD_LAST) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    assign poll_start = (period_cnt == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
            buttons   <= '0;
            valid     <= 1'b0;
            cyc_cnt   <= '0;
            bit_idx   <= '0;
            captured  <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (poll_start) begin
                        state     <= LATCH;
                        pad_latch <= 1'b1;
                        cyc_cnt   <= LATCH_LOAD;
                        bit_idx   <= '0;
                        captured  <= '0;
                    end
                end
                LATCH: begin
                    if (cyc_cnt == '0) begin
                        captured[0] <= pd_s;
                        bit_idx     <= 3'd1;
                        pad_latch   <= 1'b0;
                        pad_clk     <= 1'b1;
                        cyc_cnt     <= CLK_LOAD;
                        state       <= CLK_HI;
                    end else begin
                        cyc_cnt <= cyc_cnt - 1'b1;
                    end
                end
                CLK_HI: begin
                    if (cyc_cnt == '0) begin
                        pad_clk <= 1'b0;
                        cyc_cnt <= CLK_LOAD;
                        state   <= CLK_LO;
                    end else begin
                        cyc_cnt <= cyc_cnt - 1'b1;
                    end
                end
                CLK_LO: begin
                    if (cyc_cnt == '0) begin
                        captured[bit_idx] <= pd_s;
                        if (bit_idx == 3'd7) begin
                            // Last bit merged directly so buttons and valid appear together in DONE.
                            buttons <= ~{pd_s, captured[6:0]};
                            valid   <= 1'b1;
                            state   <= DONE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            pad_clk <= 1'b1;
                            cyc_cnt <= CLK_LOAD;
                            state   <= CLK_HI;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Core-side 4021: strobe loads transparently and wins over a coincident falling clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            nclk_q <= 1'b0;
            sreg   <= '0;
        end else begin
            nclk_q <= nes_clock;
            if (nes_strobe) begin
                sreg <= buttons;
            end else if (nclk_q && !nes_clock) begin
                sreg <= {1'b1, sreg[7:1]};
            end
        end
    end

    assign nes_data = sreg[0];

endmodule

// File: tb/tb_joypad_poller.sv
// Bench for joypad_poller: a registered 4021 pad model feeds the DUT while a cycle-level
// reference built from the poll schedule and button/read rules checks every output each cycle.
module tb_joypad_poller;

    localparam int DIV      = 4;
    localparam int PERIOD   = 200;
    localparam int POLL_LEN = 16 * DIV;

    logic       clock = 1'b0;
    logic       reset;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] buttons;
    logic       valid;
    logic       nes_strobe;
    logic       nes_clock;
    logic       nes_data;

    always #5 clock = ~clock;

    joypad_poller #(.DIV(DIV), .POLL_PERIOD(PERIOD)) dut (
        .clock      (clock),
        .reset      (reset),
        .pad_data   (pad_data),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .buttons    (buttons),
        .valid      (valid),
        .nes_strobe (nes_strobe),
        .nes_clock  (nes_clock),
        .nes_data   (nes_data)
    );

    // Physical pad: parallel load while latched, shift on rising pad_clk, registered output.
    logic [7:0] pad_raw;
    logic [7:0] pad_sh = 8'hFF;
    logic       pad_clk_q = 1'b0;
    always @(posedge clock) begin
        pad_clk_q <= pad_clk;
        if (pad_latch) pad_sh <= pad_raw;
        else if (pad_clk && !pad_clk_q) pad_sh <= {1'b1, pad_sh[7:1]};
    end
    assign pad_data = pad_sh[0];

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         t = 0;
    logic [7:0] btn_exp = '0;
    logic [7:0] loaded = '0;
    int         k = 0;
    logic       prev_nclk = 1'b0;
    logic       exp_latch = 1'b0;
    logic       exp_clk = 1'b0;
    logic       exp_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: t counts edges since reset release; poll phase p decides the pin levels,
    // k counts bits delivered to the core since the last strobe load of 'loaded'.
    task automatic step();
        int p;
        @(posedge clock);
        cyc++;
        if (reset) begin
            t = 0;
            btn_exp = '0;
            loaded = '0;
            k = 0;
            prev_nclk = 1'b0;
            exp_latch = 1'b0;
            exp_clk = 1'b0;
            exp_valid = 1'b0;
        end else begin
            t++;
            p = (t - 1) % PERIOD;
            if (nes_strobe) begin
                loaded = btn_exp;
                k = 0;
            end else if (prev_nclk && !nes_clock && k < 8) begin
                k++;
            end
            prev_nclk = nes_clock;
            exp_latch = (p < 2 * DIV);
            exp_clk   = (p >= 2 * DIV) && (p < POLL_LEN) && (((p - 2 * DIV) % (2 * DIV)) < DIV);
            exp_valid = (p == POLL_LEN);
            if (exp_valid) btn_exp = ~pad_raw;
        end
        @(negedge clock);
        check("pad_latch", 32'(pad_latch), 32'(exp_latch));
        check("pad_clk", 32'(pad_clk), 32'(exp_clk));
        check("valid", 32'(valid), 32'(exp_valid));
        check("buttons", 32'(buttons), 32'(btn_exp));
        check("nes_data", 32'(nes_data), 32'((k < 8) ? loaded[3'(k)] : 1'b1));
    endtask

    task automatic wait_valid(input string tag, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            step();
            if (valid) begin
                at = cyc;
                break;
            end
        end
        check({tag, "_seen"}, 32'(at >= 0), 32'(1));
    endtask

    task automatic core_edge();
        nes_clock = 1'b1;
        step();
        nes_clock = 1'b0;
        step();
    endtask

    initial begin
        int         at;
        int         prev_at;
        logic [9:0] read_exp;
        logic [7:0] want;
        logic [7:0] old_word;
        logic       b;

        reset = 1'b1;
        nes_strobe = 1'b0;
        nes_clock = 1'b0;
        pad_raw = 8'hF6;
        repeat (3) step();
        check("rst_buttons", 32'(buttons), 32'(0));
        check("rst_nes_data", 32'(nes_data), 32'(0));

        // Capture A+Start from the first poll
        reset = 1'b0;
        step();
        check("first_latch", 32'(pad_latch), 32'(1));
        wait_valid("capture", 100, at);
        check("capture_time", 32'(t), 32'(POLL_LEN + 1));
        check("capture_btn", 32'(buttons), 32'(8'h09));
        prev_at = at;
        step();
        check("valid_single", 32'(valid), 32'(0));

        // Core read of 8'h09
        nes_strobe = 1'b1;
        step();
        nes_strobe = 1'b0;
        step();
        check("read_bit0", 32'(nes_data), 32'(1));
        read_exp = 10'b11_1000_0100;
        for (int e = 0; e < 10; e++) begin
            core_edge();
            check($sformatf("read_edge%0d", e + 1), 32'(nes_data), 32'(read_exp[e]));
        end

        // Random pad states, spacing and random core reads
        for (int n = 0; n < 4; n++) begin
            pad_raw = 8'($urandom);
            want = ~pad_raw;
            wait_valid("poll", 250, at);
            check("poll_spacing", 32'(at - prev_at), 32'(PERIOD));
            check("poll_btn", 32'(buttons), 32'(want));
            prev_at = at;
            nes_strobe = 1'b1;
            step();
            nes_strobe = 1'b0;
            for (int e = 0; e < 9; e++) core_edge();
        end

        // A buttons update during a read must not disturb the bits still to come
        old_word = ~pad_raw;
        nes_strobe = 1'b1;
        step();
        nes_strobe = 1'b0;
        for (int e = 0; e < 3; e++) core_edge();
        pad_raw = ~old_word ^ 8'h5A;
        wait_valid("midread", 250, at);
        prev_at = at;
        for (int e = 3; e < 9; e++) begin
            core_edge();
            check($sformatf("midread_edge%0d", e + 1), 32'(nes_data),
                  32'((e + 1 < 8) ? old_word[3'(e + 1)] : 1'b1));
        end

        // Strobe held high across a poll: nes_data follows buttons[0], no shifting
        nes_strobe = 1'b1;
        pad_raw = 8'($urandom);
        pad_raw[0] = btn_exp[0];
        for (int i = 0; i < 250; i++) begin
            nes_clock = 1'($urandom);
            step();
        end
        b = ~pad_raw[0];
        check("strobe_track", 32'(nes_data), 32'(b));
        nes_strobe = 1'b0;
        nes_clock = 1'b0;
        step();

        // Reset at cycle 20 of a poll
        for (int i = 0; i < 250 && ((t - 1) % PERIOD) != 19; i++) step();
        check("mid_align", 32'((t - 1) % PERIOD), 32'(19));
        reset = 1'b1;
        step();
        check("abort_latch", 32'(pad_latch), 32'(0));
        check("abort_clk", 32'(pad_clk), 32'(0));
        check("abort_buttons", 32'(buttons), 32'(0));
        check("abort_nes_data", 32'(nes_data), 32'(0));
        check("abort_valid", 32'(valid), 32'(0));
        repeat (2) step();
        reset = 1'b0;
        step();
        check("restart_latch", 32'(pad_latch), 32'(1));
        want = ~pad_raw;
        wait_valid("restart", 100, at);
        check("restart_time", 32'(t), 32'(POLL_LEN + 1));
        check("restart_btn", 32'(buttons), 32'(want));
        prev_at = at;

        // Periodicity with a constant pad
        for (int n = 0; n < 5; n++) begin
            wait_valid("period", 250, at);
            check("period_spacing", 32'(at - prev_at), 32'(PERIOD));
            check("period_btn", 32'(buttons), 32'(want));
            prev_at = at;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/joypad_poller.md
# joypad_poller

Autonomous NES controller interface between the physical pad pins and the NES core's joypad port. It polls the pad at a fixed frame-rate interval, synchronizes the serial data and captures a stable 8-bit button word. It then presents that word to the core through a cycle-accurate emulation of the 4021 shift register, driven by the core's own strobe/clock. This decouples pad-pin timing from CPU read timing and removes the ad-hoc `joy_data_sync` logic from the top level.

## Interface
- `DIV`, 64: system-clock cycles per pad half-period. Must be ≥ 4.
- `POLL_PERIOD`, 357954: cycles between poll starts, about 60 Hz at 21.477 MHz. Must be > 16*`DIV`.
- `clock`  in  1: system clock (one clock domain).
- `reset`  in  1: synchronous, active-high.
- `pad_data`  in  1: raw serial data from the pad, active-low (low = pressed), asynchronous.
- `pad_latch`  out  1: latch pulse to the pad.
- `pad_clk`  out  1: shift clock to the pad.
- `buttons`  out  8: captured buttons, active-high. Bit order: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
- `valid`  out  1: one-cycle pulse when `buttons` updates.
- `nes_strobe`  in  1: core's $4016 bit0 strobe.
- `nes_clock`  in  1: core's joypad read clock.
- `nes_data`  out  1: serial bit to the core, active-high (1 = pressed).

## Operation
- **Synchronizer.** `pad_data` passes through a 2-flop synchronizer. All sampling uses the synchronized copy, `pd_s`.
- **Period counter.** Width is `$clog2(POLL_PERIOD)`. It counts 0..`POLL_PERIOD`-1 and wraps. When it equals 0 and the FSM is IDLE, a poll starts.
- **Poll FSM states:** IDLE, LATCH, CLK_HI, CLK_LO, DONE.
  - IDLE → LATCH on the trigger. The shift register and bit index (3 bits) are cleared.
  - LATCH: `pad_latch`=1 for 2*`DIV` cycles. On the last cycle, sample `pd_s` into bit 0, then go to CLK_HI with index=1.
  - CLK_HI: `pad_clk`=1 for `DIV` cycles, then go to CLK_LO.
  - CLK_LO: `pad_clk`=0 for `DIV` cycles. On the last cycle, sample `pd_s` into bit[index]. If index==7, go to DONE; otherwise increment index and go to CLK_HI.
  - DONE (1 cycle): `buttons` <= ~captured; `valid`=1; go to IDLE.
  - A single `DIV`-range cycle counter is shared by all timed states and reloads on each state entry.
- **Core-side emulated register** (8-bit `sreg`; `nes_data` = `sreg[0]`):
  - `nes_strobe`=1: `sreg` <= `buttons` every cycle. This is transparent, so a `buttons` update lands in `sreg` on the next cycle.
  - Falling edge of `nes_clock`, detected as last=1 and now=0 using a registered copy, with `nes_strobe`=0: `sreg` <= {1'b1, `sreg[7:1]`}. After 8 shifts, `nes_data` reads 1, matching official pads.
  - Strobe has priority over a simultaneous clock edge.
  - `buttons` updates while `nes_strobe`=0 do not disturb an in-progress core read.

## Timing
- **Reset values:** `pad_latch`=0, `pad_clk`=0, `buttons`=0, `valid`=0, `sreg`=0, `nes_data`=0. FSM=IDLE, period counter=0, clock-edge register=0.
- **Reset mid-poll:** aborts the poll. Outputs take their reset values on the cycle after `reset` is sampled high. No `valid` is issued and `buttons` returns to 0.
- **First poll:** `pad_latch` rises on the 1st cycle after `reset` deasserts. Polls then repeat every `POLL_PERIOD` cycles.
- **Poll duration:** LATCH to DONE is 2*`DIV` + 14*`DIV` = 16*`DIV` cycles. `valid` asserts 16*`DIV` cycles after `pad_latch` rises, with `buttons` updated in the same cycle.
- **Pad waveform:** exactly 7 `pad_clk` pulses per poll, each high for `DIV` cycles then low for `DIV` cycles.
- **Sampling margin:** each sample is taken `DIV` cycles after the corresponding pad edge. Since `DIV` ≥ 4, the 2-cycle synchronizer latency is covered.
- **Core path latency:** `nes_data` changes 1 cycle after the detected `nes_clock` falling edge or the strobe-load cycle.

## Test plan
All scenarios use a bench with `DIV`=4 and `POLL_PERIOD`=200, and a pad model that is a 4021 model with registered outputs.
- **Capture.** Release reset with pad pressing A+Start (pad bits 0 and 3 low) → exactly one `valid` pulse at cycle 64 after `pad_latch` rises, with `buttons`=8'h09.
- **Pad waveform.** Run one poll → `pad_latch` high for exactly 8 cycles, then 7 `pad_clk` pulses each 4 cycles high / 4 cycles low. Both pins are otherwise 0.
- **Core read.** With `buttons`=8'h09: `nes_strobe` 1→0, then 10 `nes_clock` falling edges → `nes_data` reads 1 before the first edge, then 0,0,1,0,0,0,0 after edges 1-7, then 1 after edges 8-10.
- **Strobe held high.** Hold `nes_strobe`=1, toggle `nes_clock`, and change pad state across a poll → `nes_data` tracks `buttons[0]`, one cycle after `valid`. No shifting occurs.
- **Reset mid-poll.** Assert `reset` at cycle 20 of a poll → `pad_latch`, `pad_clk`, `buttons` and `nes_data` are 0 the next cycle, with no `valid`. After release, a new poll starts on cycle 1.
- **Periodicity.** Run for 1000 cycles with a constant pad state → `valid` pulses are spaced exactly 200 cycles apart and `buttons` is stable.
